// File: rtl/x_top_rv32i_param.sv
`default_nettype none
// ============================================================================
// Module      : x_top_rv32i_param
// Description : Parametrised multi-cycle RV32I core on one shared valid/accept
//               memory port. Halts in a sticky trap on illegal instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module x_top_rv32i_param #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          NREGS          = 32,
    parameter bit          TRAP_ON_SYSTEM = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data,
    input  logic        i_accept,
    output logic        o_valid,
    output logic        o_rnw,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_strb,
    output logic        o_trap,
    output logic [31:0] o_trap_pc
);

    localparam int c_AW = (NREGS == 16) ? 4 : 5;

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_TRAP   = 3'd4;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [2:0]  r_state, w_next_state;
    logic [31:0] r_pc, r_ir, r_trap_pc;
    logic [31:0] r_regs [NREGS];

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[c_AW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[c_AW-1:0]];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u = {r_ir[31:12], 12'd0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    logic w_legal, w_use_rs1, w_use_rs2, w_use_rd, w_is_load, w_is_store, w_is_system;

    always_comb begin
        w_legal     = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_use_rd    = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_system = 1'b0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
            end
            c_OP_JALR: begin
                w_legal   = (w_f3 == 3'd0);
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
            end
            c_OP_BRANCH: begin
                w_legal   = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_LOAD: begin
                w_legal   = w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_is_load = 1'b1;
            end
            c_OP_STORE: begin
                w_legal    = (w_f3 <= 3'd2);
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_is_store = 1'b1;
            end
            c_OP_IMM: begin
                if (w_f3 == 3'd1)
                    w_legal = (w_f7 == 7'h00);
                else if (w_f3 == 3'd5)
                    w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                else
                    w_legal = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
            end
            c_OP_REG: begin
                w_legal   = (w_f7 == 7'h00) ||
                            ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
            end
            c_OP_FENCE: w_legal = (w_f3 == 3'd0);
            c_OP_SYSTEM: begin
                w_legal     = (r_ir == 32'h0000_0073) || (r_ir == 32'h0010_0073);
                w_is_system = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    logic [31:0] w_alu_b, w_alu_res;
    logic [4:0]  w_shamt;

    assign w_alu_b = (w_opcode == c_OP_REG) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];

    always_comb begin
        w_alu_res = 32'd0;
        case (w_f3)
            3'd0: w_alu_res = ((w_opcode == c_OP_REG) && r_ir[30]) ? (w_rs1_val - w_alu_b)
                                                                   : (w_rs1_val + w_alu_b);
            3'd1: w_alu_res = w_rs1_val << w_shamt;
            3'd2: w_alu_res = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'd3: w_alu_res = {31'd0, w_rs1_val < w_alu_b};
            3'd4: w_alu_res = w_rs1_val ^ w_alu_b;
            3'd5: w_alu_res = r_ir[30] ? $unsigned($signed(w_rs1_val) >>> w_shamt)
                                       : (w_rs1_val >> w_shamt);
            3'd6: w_alu_res = w_rs1_val | w_alu_b;
            default: w_alu_res = w_rs1_val & w_alu_b;
        endcase
    end

    logic        w_take;
    logic [31:0] w_pc4, w_next_pc;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_take = 1'b0;
        case (w_f3)
            3'd0: w_take = (w_rs1_val == w_rs2_val);
            3'd1: w_take = (w_rs1_val != w_rs2_val);
            3'd4: w_take = ($signed(w_rs1_val) < $signed(w_rs2_val));
            3'd5: w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'd6: w_take = (w_rs1_val < w_rs2_val);
            3'd7: w_take = (w_rs1_val >= w_rs2_val);
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_pc4;
        case (w_opcode)
            c_OP_JAL:    w_next_pc = r_pc + w_imm_j;
            c_OP_JALR:   w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            c_OP_BRANCH: w_next_pc = w_take ? (r_pc + w_imm_b) : w_pc4;
            default:     w_next_pc = w_pc4;
        endcase
    end

    logic [31:0] w_mem_addr;
    logic        w_misalign, w_target_bad, w_bad_reg, w_trap;

    assign w_mem_addr = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);

    always_comb begin
        w_misalign = 1'b0;
        if (w_is_load || w_is_store) begin
            case (w_f3[1:0])
                2'd1:    w_misalign = w_mem_addr[0];
                2'd2:    w_misalign = (w_mem_addr[1:0] != 2'd0);
                default: w_misalign = 1'b0;
            endcase
        end
    end

    // pc+4 is always aligned, so only redirected targets need checking.
    assign w_target_bad = ((w_opcode == c_OP_JAL) || (w_opcode == c_OP_JALR) ||
                           ((w_opcode == c_OP_BRANCH) && w_take)) && w_next_pc[1];

    assign w_bad_reg = (NREGS == 16) && ((w_use_rs1 && w_rs1[4]) ||
                                         (w_use_rs2 && w_rs2[4]) ||
                                         (w_use_rd  && w_rd[4]));

    assign w_trap = !w_legal || w_bad_reg || w_target_bad || w_misalign ||
                    (w_is_system && TRAP_ON_SYSTEM);

    logic [31:0] w_ld_shift, w_ld_val, w_wb_val, w_wd;
    logic        w_we;

    assign w_ld_shift = i_data >> {w_mem_addr[1:0], 3'b000};

    always_comb begin
        case (w_f3)
            3'd0:    w_ld_val = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'd1:    w_ld_val = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'd4:    w_ld_val = {24'd0, w_ld_shift[7:0]};
            3'd5:    w_ld_val = {16'd0, w_ld_shift[15:0]};
            default: w_ld_val = w_ld_shift;
        endcase
    end

    always_comb begin
        case (w_opcode)
            c_OP_LUI:           w_wb_val = w_imm_u;
            c_OP_AUIPC:         w_wb_val = r_pc + w_imm_u;
            c_OP_JAL, c_OP_JALR: w_wb_val = w_pc4;
            default:            w_wb_val = w_alu_res;
        endcase
    end

    assign w_we = ((r_state == c_EXEC) && w_use_rd) ||
                  ((r_state == c_MEM) && i_accept && w_is_load);
    assign w_wd = (r_state == c_MEM) ? w_ld_val : w_wb_val;

    logic [31:0] w_st_data;
    logic [3:0]  w_st_strb;

    always_comb begin
        case (w_f3[1:0])
            2'd0: begin
                w_st_data = {4{w_rs2_val[7:0]}};
                w_st_strb = 4'b0001 << w_mem_addr[1:0];
            end
            2'd1: begin
                w_st_data = {2{w_rs2_val[15:0]}};
                w_st_strb = w_mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = w_rs2_val;
                w_st_strb = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst)
            r_state <= c_FETCH;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH:  if (i_accept) w_next_state = c_DECODE;
            c_DECODE: begin
                if (w_trap)
                    w_next_state = c_TRAP;
                else if (w_is_load || w_is_store)
                    w_next_state = c_MEM;
                else
                    w_next_state = c_EXEC;
            end
            c_EXEC:   w_next_state = c_FETCH;
            c_MEM:    if (i_accept) w_next_state = c_FETCH;
            c_TRAP:   w_next_state = c_TRAP;
            default:  w_next_state = c_FETCH;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_rnw   = 1'b1;
        o_addr  = 32'd0;
        o_data  = 32'd0;
        o_strb  = 4'd0;
        case (r_state)
            c_FETCH: begin
                o_valid = 1'b1;
                o_addr  = r_pc;
                o_strb  = 4'b1111;
            end
            c_MEM: begin
                o_valid = 1'b1;
                o_rnw   = !w_is_store;
                o_addr  = w_mem_addr;
                o_data  = w_is_store ? w_st_data : 32'd0;
                o_strb  = w_is_store ? w_st_strb : 4'b1111;
            end
            default: ;
        endcase
    end

    assign o_trap    = (r_state == c_TRAP);
    assign o_trap_pc = r_trap_pc;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_trap_pc <= 32'd0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= 32'd0;
        end else begin
            if ((r_state == c_FETCH) && i_accept)
                r_ir <= i_data;
            if ((r_state == c_DECODE) && w_trap)
                r_trap_pc <= r_pc;
            if (r_state == c_EXEC)
                r_pc <= w_next_pc;
            if ((r_state == c_MEM) && i_accept)
                r_pc <= w_pc4;
            if (w_we && (w_rd != 5'd0))
                r_regs[w_rd[c_AW-1:0]] <= w_wd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x_top_rv32i_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_top_rv32i_param
// Description : Directed self-checking bench for x_top_rv32i_param (RV32E build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x_top_rv32i_param;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        acc = 1'b1;
    logic        block_data = 1'b0;
    logic [31:0] i_data;
    logic        i_accept;
    logic        o_valid, o_rnw, o_trap;
    logic [31:0] o_addr, o_data, o_trap_pc;
    logic [3:0]  o_strb;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          dcount = 0;

    always #5 clk = ~clk;

    x_top_rv32i_param #(
        .RESET_PC       (32'h0000_0100),
        .NREGS          (16),
        .TRAP_ON_SYSTEM (1'b1)
    ) u_dut (
        .i_clk     (clk),
        .i_nrst    (nrst),
        .i_data    (i_data),
        .i_accept  (i_accept),
        .o_valid   (o_valid),
        .o_rnw     (o_rnw),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .o_strb    (o_strb),
        .o_trap    (o_trap),
        .o_trap_pc (o_trap_pc)
    );

    // Addresses >= 0x200 are data; block_data stalls data accesses only.
    assign i_accept = acc && !(block_data && o_valid && (o_addr >= 32'h200));
    assign i_data   = mem[o_addr[9:2]];

    always @(posedge clk) begin
        if (o_valid && i_accept && (o_addr >= 32'h200))
            dcount = dcount + 1;
        if (o_valid && i_accept && !o_rnw)
            for (int k = 0; k < 4; k++)
                if (o_strb[k])
                    mem[o_addr[9:2]][8*k +: 8] = o_data[8*k +: 8];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] f_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] f_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] f_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] f_u(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction

    function automatic logic [31:0] f_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic wait_store(output logic [31:0] addr, output logic [31:0] data,
                              output logic [3:0] strb, output int cyc);
        logic found;
        found = 1'b0;
        addr = 32'd0;
        data = 32'd0;
        strb = 4'd0;
        cyc = 0;
        for (int i = 1; i <= 200 && !found; i++) begin
            @(negedge clk);
            if (o_valid && !o_rnw && i_accept) begin
                found = 1'b1;
                addr = o_addr;
                data = o_data;
                strb = o_strb;
                cyc = i;
            end
        end
        check("store_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_trap();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = o_trap;
        end
        check("trap_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic expect_store(input string tag, input logic [31:0] exp_addr,
                                input logic [31:0] exp_data);
        logic [31:0] a, d;
        logic [3:0]  s;
        int          c;
        wait_store(a, d, s, c);
        check({tag, "_addr"}, a, exp_addr);
        check({tag, "_data"}, d, exp_data);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int          c;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = f_i(32'hFFFF_FFFF, 0, 0, 1, 7'h13);   // ADDI x1,x0,-1
        mem[32'h104 >> 2] = f_i(32'h404, 1, 5, 2, 7'h13);         // SRAI x2,x1,4
        mem[32'h108 >> 2] = f_i(32'd28, 1, 5, 3, 7'h13);          // SRLI x3,x1,28
        mem[32'h10C >> 2] = f_r(7'h00, 1, 0, 3, 4, 7'h33);        // SLTU x4,x0,x1
        mem[32'h110 >> 2] = f_s(32'h300, 2, 0, 2);
        mem[32'h114 >> 2] = f_s(32'h304, 3, 0, 2);
        mem[32'h118 >> 2] = f_s(32'h308, 4, 0, 2);
        mem[32'h11C >> 2] = f_u(32'h8899B, 5, 7'h37);             // LUI x5
        mem[32'h120 >> 2] = f_i(32'hABB, 5, 0, 5, 7'h13);         // x5 = 0x8899AABB
        mem[32'h124 >> 2] = f_s(32'h200, 5, 0, 2);
        mem[32'h128 >> 2] = f_i(32'h201, 0, 0, 6, 7'h03);         // LB x6
        mem[32'h12C >> 2] = f_i(32'h202, 0, 5, 7, 7'h03);         // LHU x7
        mem[32'h130 >> 2] = f_s(32'h30C, 6, 0, 2);
        mem[32'h134 >> 2] = f_s(32'h310, 7, 0, 2);
        mem[32'h138 >> 2] = f_i(32'h55, 0, 0, 8, 7'h13);
        mem[32'h13C >> 2] = f_s(32'h203, 8, 0, 0);                // SB
        mem[32'h140 >> 2] = f_j(32'hFFFF_FF00, 9);                // JAL x9 -> 0x40
        mem[32'h040 >> 2] = f_b(32'd16, 0, 1, 4);                 // BLT x1,x0,+16
        mem[32'h044 >> 2] = f_s(32'h314, 1, 0, 2);
        mem[32'h048 >> 2] = f_s(32'h314, 1, 0, 2);
        mem[32'h04C >> 2] = f_s(32'h314, 1, 0, 2);
        mem[32'h050 >> 2] = f_s(32'h314, 9, 0, 2);
        mem[32'h054 >> 2] = f_i(32'h10, 9, 0, 10, 7'h67);         // JALR x10,x9,16
        mem[32'h058 >> 2] = f_s(32'h318, 1, 0, 2);
        mem[32'h154 >> 2] = f_s(32'h318, 10, 0, 2);
        mem[32'h158 >> 2] = f_r(7'h20, 1, 5, 0, 11, 7'h33);       // SUB x11,x5,x1
        mem[32'h15C >> 2] = f_s(32'h31C, 11, 0, 2);
        mem[32'h160 >> 2] = f_i(32'd5, 0, 0, 0, 7'h13);           // ADDI x0,x0,5
        mem[32'h164 >> 2] = f_s(32'h320, 0, 0, 2);
        mem[32'h168 >> 2] = f_i(32'h202, 0, 2, 13, 7'h03);        // misaligned LW

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, o_valid}, 32'd1);
        check("rst_addr", o_addr, 32'h100);
        check("rst_rnw_strb", {27'd0, o_rnw, o_strb}, 32'h1F);
        check("rst_trap", {31'd0, o_trap}, 32'd0);
        check("rst_trap_pc", o_trap_pc, 32'd0);
        nrst = 1'b1;

        wait_store(a, d, s, c);
        check("latency_first_store", c, 32'd14);
        check("srai_addr", a, 32'h300);
        check("srai", d, 32'hFFFF_FFFF);
        expect_store("srli", 32'h304, 32'h0000_000F);
        expect_store("sltu", 32'h308, 32'h0000_0001);
        wait_store(a, d, s, c);
        check("sw_addr", a, 32'h200);
        check("sw_data", d, 32'h8899_AABB);
        check("sw_strb", {28'd0, s}, 32'hF);
        expect_store("lb", 32'h30C, 32'hFFFF_FFAA);
        expect_store("lhu", 32'h310, 32'h0000_8899);
        wait_store(a, d, s, c);
        check("sb_addr", a, 32'h203);
        check("sb_data", d, 32'h5555_5555);
        check("sb_strb", {28'd0, s}, 32'h8);

        @(negedge clk);
        acc = 1'b0;
        check("stall_addr0", o_addr, 32'h140);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_addr", o_addr, 32'h140);
            check("stall_ctl", {26'd0, o_valid, o_rnw, o_strb}, 32'h3F);
        end
        acc = 1'b1;

        expect_store("jal_blt", 32'h314, 32'h0000_0144);
        expect_store("jalr", 32'h318, 32'h0000_0058);
        expect_store("sub", 32'h31C, 32'h8899_AABC);
        expect_store("x0", 32'h320, 32'h0000_0000);
        wait_trap();
        check("lw_trap_pc", o_trap_pc, 32'h168);
        check("trap_idle", {o_valid, o_strb, o_addr[26:0]}, 32'd0);
        check("trap_no_mem", dcount, 32'd13);

        nrst = 1'b0;
        mem[32'h100 >> 2] = f_r(7'h00, 2, 1, 0, 17, 7'h33);       // ADD x17,x1,x2
        @(posedge clk);
        @(negedge clk);
        check("rst_clears_trap", {31'd0, o_trap}, 32'd0);
        check("rst_clears_trap_pc", o_trap_pc, 32'd0);
        nrst = 1'b1;
        wait_trap();
        check("rv32e_trap_pc", o_trap_pc, 32'h100);

        nrst = 1'b0;
        mem[32'h100 >> 2] = f_i(32'hFFFF_FFFF, 0, 0, 1, 7'h13);
        mem[32'h104 >> 2] = f_i(32'h200, 0, 2, 2, 7'h03);         // LW x2,0x200
        block_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk);
                found = o_valid && (o_addr == 32'h200);
            end
            check("mem_stall_seen", {31'd0, found}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mem_stall_hold", {o_valid, o_rnw, o_addr[29:0]}, {2'b11, 30'h200});
        end
        nrst = 1'b0;
        mem[32'h100 >> 2] = f_s(32'h320, 1, 0, 2);                // SW x1,0x320
        block_data = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_fetch", {o_valid, o_rnw, o_addr[29:0]}, {2'b11, 30'h100});
        nrst = 1'b1;
        expect_store("regs_cleared", 32'h320, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/x_top_rv32i_param.md
Name: x_top_rv32i_param

Overview:
- Parametrised multi-cycle RV32I integer core; next generation of the single-port fetch/execute core.
- Drives one shared valid/accept memory port (fetch, load, store).
- Adds over the previous generation:
  - full RV32I base ALU, branch and jump set; sub-word loads/stores with byte strobes;
  - configurable reset PC and register count (RV32E when NREGS=16);
  - sticky trap on illegal, misaligned or system instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NREGS, 32, architectural register count; legal values 16 or 32.
TRAP_ON_SYSTEM, 1, 1: ECALL/EBREAK trap; 0: ECALL/EBREAK/FENCE execute as NOP.

Ports:
i_clk  in  1  clock.
i_nrst  in  1  reset, synchronous, active-low.
i_data  in  32  read data: instruction word or aligned load word.
i_accept  in  1  memory accepts the current request this cycle; read data valid the same cycle.
o_valid  out  1  memory request pending.
o_rnw  out  1  1 = read, 0 = write.
o_addr  out  32  byte address; fetch is word-aligned.
o_data  out  32  store data, replicated to lanes (SB: byte x4, SH: half x2).
o_strb  out  4  write byte lanes; 4'b1111 on reads.
o_trap  out  1  core halted in TRAP, sticky.
o_trap_pc  out  32  PC of the trapping instruction.

Behaviour:
- Reset is synchronous: on any i_clk edge with i_nrst=0:
  - state=FETCH, pc=RESET_PC, all regs=0, instruction reg=0, trap_pc=0;
  - applies mid-transaction; the pending request is dropped with no handshake.
- States and transitions:
  - FETCH: valid=1, rnw=1, addr=pc. On accept, latch i_data, go DECODE.
  - DECODE: 1 cycle. Classify opcode[6:0]; to EXEC, MEM or TRAP.
  - EXEC: 1 cycle. ALU/LUI/AUIPC/JAL/JALR/branch; write rd; update pc; go FETCH.
  - MEM: valid=1, addr=rs1+sext(imm), held stable until accept. Load writes rd at accept. Then pc+=4, go FETCH.
  - TRAP: valid=0, o_trap=1; left only by reset.
- Latency with accept always 1:
  - ALU/jump/branch: 3 cycles (FETCH, DECODE, EXEC).
  - Load/store: 3 cycles (FETCH, DECODE, MEM).
- Handshake: o_valid, o_addr, o_rnw, o_data and o_strb stay constant while o_valid=1 and i_accept=0. o_valid may not drop without accept except on reset.
- Outputs outside FETCH/MEM: valid=0, rnw=1, strb=0, addr=0, data=0. o_trap_pc=0 until a trap occurs.
- ALU set:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and their immediate forms.
  - Shift amount is [4:0] of rs2 or imm.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned, with the immediate sign-extended before the unsigned compare.
- Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU. Target = pc+sext(B-imm), otherwise pc+4. All 32-bit add wraps modulo 2^32.
- JAL: rd=pc+4; pc=pc+sext(J-imm).
- JALR: target=(rs1+sext(imm)) & ~1; rd=old pc+4. rs1 is read before rd is written, so rd==rs1 is legal.
- LUI: rd={imm,12'b0}. AUIPC: rd=pc+{imm,12'b0}.
- Loads: LB, LH, LW, LBU, LHU. Lane select = addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores:
  - SB strb = 1<<addr[1:0];
  - SH strb = 4'b0011 or 4'b1100 by addr[1];
  - SW strb = 4'b1111.
- x0 reads 0; writes to x0 are discarded.
- Trap conditions, all detected before any architectural update (no rd write, no memory request, pc unchanged):
  - unknown opcode or funct;
  - any rs1/rs2/rd index >= NREGS;
  - misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0);
  - taken branch or jump target with target[1]=1;
  - ECALL/EBREAK when TRAP_ON_SYSTEM=1.
- Misaligned memory address is computed in DECODE; pc is unchanged on this trap as on all traps.
- On trap: o_trap_pc=pc.
- FENCE is always a NOP: pc+=4 via EXEC.

Test Plan:
- Reset with RESET_PC=32'h100, accept held 1 -> first request addr=0x100, rnw=1, strb=4'hF on the cycle after i_nrst rises.
- ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28; SLTU x4,x0,x1 -> x2=0xFFFFFFFF, x3=0xF, x4=1; each instruction 3 cycles with accept=1.
- SW 0x8899AABB to 0x200, then LB from 0x201 and LHU from 0x202 (memory model returns 0x8899AABB) -> LB rd=0xFFFFFFAA, LHU rd=0x00008899; SB of 0x55 to 0x203 gives strb=4'b1000, data=0x55555555.
- Fetch with i_accept low for 5 cycles -> addr/rnw/valid stable throughout, no state change; BLT x1(-1),x0 at pc=0x40, offset +16 -> next fetch addr=0x50.
- LW at 0x202 -> no memory request, o_trap=1, o_trap_pc=pc of LW, no register change. With NREGS=16, ADD x17,x1,x2 -> trap. Reset then clears o_trap.
- Reset asserted while MEM stalled (accept=0) -> next cycle valid=1 for fetch at RESET_PC, all regs 0.
